rca_mp_sequencer: RTL
=====================

// Module: rca_mp_sequencer
// PURPOSE
//  Multi-precision add/subtract controller around one shared RCA_M word adder.
//  Accepts WORD_COUNT-word operands via valid/ready; feeds one word per clock LSW first.
//  Registers c_o back into c_i each cycle; assembles the wide result.
//  Returns the result with carry and flags on a valid/ready response port.
//  Wide arithmetic reuses one narrow ripple adder instead of a WORD_WIDTH*WORD_COUNT chain.
// PARAMETERS
//  WORD_WIDTH  8  width of the RCA_M instance, bits per word
//  WORD_COUNT  4  words per operand (>=1); operand width OP_W = WORD_WIDTH*WORD_COUNT
//  CNT_W       localparam, max(1,$clog2(WORD_COUNT)); word index width
// PORTS
//  clk_i          in   1     single clock, all state on rising edge
//  rst_ni         in   1     asynchronous, active-low reset
//  req_valid_i    in   1     operands valid
//  req_ready_o    out  1     block idle, may accept
//  sub_i          in   1     0: A+B+c_i ; 1: A-B-c_i (c_i = borrow-in)
//  c_i            in   1     carry/borrow in
//  a_i            in   OP_W  operand A
//  b_i            in   OP_W  operand B
//  rsp_valid_o    out  1     result valid
//  rsp_ready_i    in   1     consumer takes result
//  r_o            out  OP_W  result
//  c_o            out  1     carry out (sub: 1 = no borrow, 0 = borrow)
//  ovf_o          out  1     signed two's-complement overflow of the full OP_W op
//  z_o            out  1     r_o == 0
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE, index 0, carry reg 0, operand/result regs 0.
//   Outputs: req_ready_o=0 during reset, 1 after release; rsp_valid_o/r_o/c_o/ovf_o/z_o 0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: req_ready_o=1. On req_valid_i&&req_ready_o: latch a_i; latch b_i^{OP_W{sub_i}}.
//   Carry reg <= c_i^sub_i; index <= 0; go RUN. req_valid_i with ready=0 is ignored.
//  RUN: RCA_M a_i=A[idx], b_i=B'[idx], c_i=carry reg.
//   Each edge: R[idx] <= r_o; carry reg <= c_o; idx++.
//   On the edge with idx==WORD_COUNT-1: compute c_o, ovf_o, z_o and go DONE.
//  Flags: ovf = (A_msb==B'_msb) && (R_msb!=A_msb), on the final word.
//   z = full OP_W result zero.
//  DONE: rsp_valid_o=1; r_o/c_o/ovf_o/z_o held stable until rsp_ready_i=1.
//   On that edge: rsp_valid_o drops and state returns to IDLE.
//   req_ready_o=0 in RUN and DONE; no overlap of requests.
//  Latency: accept on edge T -> rsp_valid_o high after edge T+WORD_COUNT.
//   Min issue interval WORD_COUNT+2 cycles with rsp_ready_i tied 1.
//  Index never wraps past WORD_COUNT-1. WORD_COUNT=1: a single RUN cycle.
//  Outputs r_o/flags keep the last result until the next op completes; valid only with rsp_valid_o.
//  Reset asserted mid-RUN or mid-DONE: the in-flight op is discarded and no response is issued.
//  Width rule: all arithmetic is unsigned modulo 2^OP_W; sub is A + ~B + ~c_i.
// STRUCTURE
//  Package rca_seq_pkg: state enum typedef seq_state_t {IDLE,RUN,DONE}.
//  One sub-module: existing RCA_M #(.WORD_WIDTH(WORD_WIDTH)), instantiated exactly once.
//  Everything else (FSM, index counter, carry reg, operand/result regs) lives in this module.
// TESTING  (WORD_WIDTH=8, WORD_COUNT=4 unless stated)
//  1 add a=0x000000FF b=0x00000001 c_i=0 -> r=0x00000100, c_o=0, ovf=0, z=0; rsp_valid 4 cycles after accept.
//  2 add a=0xFFFFFFFF b=0x00000001 -> r=0x00000000, c_o=1, z=1, ovf=0.
//  3 sub a=5 b=7 c_i=0 -> r=0xFFFFFFFE, c_o=0 (borrow).
//    sub a=0x80000000 b=1 -> r=0x7FFFFFFF, ovf=1.
//    add 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
//  4 hold rsp_ready_i=0 for 5 cycles in DONE -> rsp_valid_o and r_o stable.
//    req_ready_o=0 and a pulsed req_valid_i is not accepted. Release -> IDLE next edge.
//  5 pull rst_ni low after 2 RUN cycles -> all outputs 0 immediately, no response.
//    After release, op 0x12345678+0x11111111 -> 0x23456789.
//  6 1000 random ops, random sub_i/c_i/backpressure, WORD_COUNT=1 and 4.
//    Compare against an OP_W+1-bit model of {c_o,r_o} and the ovf/z model.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// Shared types for the multi-precision RCA sequencer.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Word index width; a single-word operand still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/RCA_M.sv
// One-word ripple-carry adder: r_o = a_i + b_i + c_i, carry out on c_o.
// Purely combinational; the sequencer registers its carry between words.
module RCA_M #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic                  c_i,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic                  c_o
);

  logic [WORD_WIDTH:0] cy;

  assign cy[0] = c_i;

  for (genvar i = 0; i < WORD_WIDTH; i++) begin : gen_fa
    assign r_o[i]    = a_i[i] ^ b_i[i] ^ cy[i];
    assign cy[i+1]   = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = cy[WORD_WIDTH];

endmodule

// File: rtl/rca_mp_sequencer.sv
// Multi-precision add/subtract: one WORD_WIDTH ripple adder reused LSW first,
// WORD_COUNT cycles per op, result held on a valid/ready response port.
module rca_mp_sequencer
  import rca_seq_pkg::*;
#(
  parameter  int WORD_WIDTH = 8,
  parameter  int WORD_COUNT = 4,
  localparam int OP_W       = WORD_WIDTH * WORD_COUNT,
  localparam int CNT_W      = cnt_width(WORD_COUNT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            sub_i,
  input  logic            c_i,
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [OP_W-1:0] r_o,
  output logic            c_o,
  output logic            ovf_o,
  output logic            z_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_COUNT - 1);

  seq_state_t state_q, state_d;

  logic [CNT_W-1:0]      idx_q;
  logic                  carry_q;
  logic [OP_W-1:0]       a_q;
  logic [OP_W-1:0]       b_q;
  logic [OP_W-1:0]       acc_q;
  logic [OP_W-1:0]       res_d;
  logic [WORD_WIDTH-1:0] word_a;
  logic [WORD_WIDTH-1:0] word_b;
  logic [WORD_WIDTH-1:0] word_r;
  logic                  word_c;
  logic                  accept;
  logic                  last;

  assign req_ready_o = rst_ni && (state_q == IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign accept      = req_valid_i && req_ready_o;
  assign last        = (state_q == RUN) && (idx_q == LAST_IDX);

  assign word_a = a_q[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH];
  assign word_b = b_q[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH];

  RCA_M #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_rca (
    .a_i(word_a),
    .b_i(word_b),
    .c_i(carry_q),
    .r_o(word_r),
    .c_o(word_c)
  );

  // Full result as it will look once the current word is written back.
  always_comb begin
    res_d = acc_q;
    res_d[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH] = word_r;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow, so B and the carry are inverted at accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      r_o     <= '0;
      c_o     <= 1'b0;
      ovf_o   <= 1'b0;
      z_o     <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= a_i;
        b_q     <= b_i ^ {OP_W{sub_i}};
        carry_q <= c_i ^ sub_i;
        idx_q   <= '0;
      end
      if (state_q == RUN) begin
        acc_q   <= res_d;
        carry_q <= word_c;
        if (!last) begin
          idx_q <= idx_q + 1'b1;
        end else begin
          r_o   <= res_d;
          c_o   <= word_c;
          ovf_o <= (a_q[OP_W-1] == b_q[OP_W-1]) &&
                   (word_r[WORD_WIDTH-1] != a_q[OP_W-1]);
          z_o   <= (res_d == '0);
        end
      end
    end
  end

endmodule
